// File: rtl/efuse_pkg.sv
// Shared types, sizes and helpers for the eFuse controller slice.
package efuse_pkg;

  localparam int unsigned NR       = 64;
  localparam int unsigned RSEL     = 256 / NR;
  localparam int unsigned TMO_W    = 12;
  localparam int unsigned BYTE_NUM = NR / 8;
  localparam int unsigned BANK_W   = $clog2(RSEL);
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned SHD_W    = NR * RSEL;

  typedef enum logic [2:0] {
    LD_ISSUE = 3'd0,
    LD_WAIT  = 3'd1,
    IDLE     = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    PG_ISSUE = 3'd5,
    PG_WAIT  = 3'd6
  } ctrl_state_e;

  // Bank that holds a given fuse bit address.
  function automatic logic [BANK_W-1:0] addr2bank(input logic [ADDR_W-1:0] addr);
    return BANK_W'(32'(addr) / (BYTE_NUM * 8));
  endfunction

endpackage

// File: rtl/efuse_ctrl_if.sv
// Software request/acknowledge bus between the register block and efuse_ctrl.
interface efuse_ctrl_if;
  import efuse_pkg::*;

  logic              sw_rd_req;
  logic [BANK_W-1:0] sw_rd_sel;
  logic              sw_pg_req;
  logic [ADDR_W-1:0] sw_pg_addr;
  logic              sw_pg_allow;
  logic              sw_ack;
  logic              sw_err;

  modport master (
    output sw_rd_req, sw_rd_sel, sw_pg_req, sw_pg_addr, sw_pg_allow,
    input  sw_ack, sw_err
  );

  modport slave (
    input  sw_rd_req, sw_rd_sel, sw_pg_req, sw_pg_addr, sw_pg_allow,
    output sw_ack, sw_err
  );

endinterface

// File: rtl/efuse_wdt.sv
// Engine watchdog: clear/enable counter that saturates and flags all-ones.
module efuse_wdt #(
  parameter int unsigned TMO_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired_c = &cnt;

endmodule

// File: rtl/efuse_ctrl.sv
// eFuse sequencer: autoloads all banks into a shadow file, then arbitrates
// software read/program requests onto the engines under a watchdog.
// Optional build macro: EFUSE_RELOAD_AFTER_PGM_EN (reload programmed bank before ack).
module efuse_ctrl
  import efuse_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  efuse_ctrl_if.slave       sw,
  output logic              load_done,
  output logic              ctrl_busy,
  output logic [SHD_W-1:0]  shadow_data,
  output logic              rd_start,
  output logic [BANK_W-1:0] rd_sel,
  input  logic              rd_done,
  input  logic [NR-1:0]     rd_data,
  output logic              pg_start,
  output logic [ADDR_W-1:0] pg_addr,
  input  logic              pg_done
);

  ctrl_state_e                  state, state_nxt;
  logic [BANK_W-1:0]            ptr, ptr_nxt, rd_sel_nxt;
  logic [ADDR_W-1:0]            pg_addr_nxt;
  logic                         load_done_nxt, ack_nxt, err_nxt, shd_we;
  logic                         wdt_clr, wdt_en, wdt_exp_c;
  logic                         rd_done_c, pg_done_c;
  logic [RSEL-1:0][NR-1:0]      shadow_q;

  // Done is stale during the start cycle; the engine clears it on that edge.
  assign rd_done_c = rd_done && !rd_start;
  assign pg_done_c = pg_done && !pg_start;

  assign wdt_clr = (state == LD_ISSUE) || (state == RD_ISSUE) || (state == PG_ISSUE);
  assign wdt_en  = (state == LD_WAIT)  || (state == RD_WAIT)  || (state == PG_WAIT);

  efuse_wdt #(.TMO_W(TMO_W)) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr       (wdt_clr),
    .en        (wdt_en),
    .expired_c (wdt_exp_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    rd_sel_nxt    = rd_sel;
    pg_addr_nxt   = pg_addr;
    load_done_nxt = load_done;
    ack_nxt       = 1'b0;
    err_nxt       = sw.sw_err;
    shd_we        = 1'b0;

    unique case (state)
      LD_ISSUE: begin
        rd_sel_nxt = ptr;
        state_nxt  = LD_WAIT;
      end
      LD_WAIT: begin
        if (rd_done_c || wdt_exp_c) begin
          shd_we = rd_done_c;
          if (!rd_done_c) err_nxt = 1'b1;
          if (ptr == BANK_W'(RSEL - 1)) begin
            load_done_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            ptr_nxt   = ptr + BANK_W'(1);
            state_nxt = LD_ISSUE;
          end
        end
      end
      IDLE: begin
        // The ack cycle still sees the old request level; arbitrate only after it.
        if (load_done && !sw.sw_ack) begin
          if (sw.sw_pg_req) begin
            if (sw.sw_pg_allow) begin
              pg_addr_nxt = sw.sw_pg_addr;
              err_nxt     = 1'b0;
              state_nxt   = PG_ISSUE;
            end else begin
              ack_nxt = 1'b1;
              err_nxt = 1'b1;
            end
          end else if (sw.sw_rd_req) begin
            rd_sel_nxt = sw.sw_rd_sel;
            err_nxt    = 1'b0;
            state_nxt  = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (rd_done_c) begin
          shd_we    = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (wdt_exp_c) begin
          err_nxt   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      PG_ISSUE: state_nxt = PG_WAIT;
      PG_WAIT: begin
        if (pg_done_c) begin
`ifdef EFUSE_RELOAD_AFTER_PGM_EN
          rd_sel_nxt = addr2bank(pg_addr);
          state_nxt  = RD_ISSUE;
`else
          ack_nxt    = 1'b1;
          state_nxt  = IDLE;
`endif
        end else if (wdt_exp_c) begin
          err_nxt   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = LD_ISSUE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_ISSUE;
      ptr        <= '0;
      rd_sel     <= '0;
      pg_addr    <= '0;
      load_done  <= 1'b0;
      sw.sw_ack  <= 1'b0;
      sw.sw_err  <= 1'b0;
      ctrl_busy  <= 1'b0;
      rd_start   <= 1'b0;
      pg_start   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      rd_sel     <= rd_sel_nxt;
      pg_addr    <= pg_addr_nxt;
      load_done  <= load_done_nxt;
      sw.sw_ack  <= ack_nxt;
      sw.sw_err  <= err_nxt;
      ctrl_busy  <= (state_nxt != IDLE);
      rd_start   <= (state == LD_ISSUE) || (state == RD_ISSUE);
      pg_start   <= (state == PG_ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (shd_we) begin
      shadow_q[rd_sel] <= rd_data;
    end
  end

  assign shadow_data = shadow_q;

endmodule

// File: tb/tb_efuse_ctrl.sv
// Scoreboard bench for efuse_ctrl with behavioural read/program engine models.
module tb_efuse_ctrl;
  import efuse_pkg::*;

  localparam int unsigned BIT_W = $clog2(NR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  efuse_ctrl_if sw();

  logic              load_done, ctrl_busy, rd_start, rd_done, pg_start, pg_done;
  logic [SHD_W-1:0]  shadow_data;
  logic [BANK_W-1:0] rd_sel;
  logic [NR-1:0]     rd_data;
  logic [ADDR_W-1:0] pg_addr;

  efuse_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .load_done   (load_done),
    .ctrl_busy   (ctrl_busy),
    .shadow_data (shadow_data),
    .rd_start    (rd_start),
    .rd_sel      (rd_sel),
    .rd_done     (rd_done),
    .rd_data     (rd_data),
    .pg_start    (pg_start),
    .pg_addr     (pg_addr),
    .pg_done     (pg_done)
  );

  // Engine models: fuse array persists across rst; engines themselves reset.
  bit                      fuse_ok;
  bit                      rd_stall, pg_stall;
  logic [RSEL-1:0][NR-1:0] fuse;
  logic                    rd_busy, pg_busy;
  logic [2:0]              rd_cnt, pg_cnt;
  logic [BANK_W-1:0]       rd_bank;
  logic [ADDR_W-1:0]       pg_a;

  always @(posedge clk) begin
    if (rst) begin
      rd_done <= 1'b0; pg_done <= 1'b0; rd_busy <= 1'b0; pg_busy <= 1'b0;
      rd_cnt <= '0; pg_cnt <= '0; rd_bank <= '0; pg_a <= '0; rd_data <= '0;
      if (!fuse_ok) begin
        fuse[0] <= 64'hA5A5_A5A5_A5A5_A5A5;
        fuse[1] <= 64'h5A5A_5A5A_5A5A_5A5A;
        fuse[2] <= 64'h0F0F_0F0F_0F0F_0F0F;
        fuse[3] <= 64'hF0F0_F0F0_F0F0_F0F0;
        fuse_ok <= 1'b1;
      end
    end else begin
      if (rd_start) begin
        rd_done <= 1'b0; rd_busy <= 1'b1; rd_bank <= rd_sel;
        rd_cnt  <= 3'($urandom_range(0, 4));
      end else if (rd_busy && !rd_stall) begin
        if (rd_cnt == 3'd0) begin
          rd_done <= 1'b1; rd_data <= fuse[rd_bank]; rd_busy <= 1'b0;
        end else rd_cnt <= rd_cnt - 3'd1;
      end
      if (pg_start) begin
        pg_done <= 1'b0; pg_busy <= 1'b1; pg_a <= pg_addr;
        pg_cnt  <= 3'($urandom_range(0, 4));
      end else if (pg_busy && !pg_stall) begin
        if (pg_cnt == 3'd0) begin
          pg_done <= 1'b1; pg_busy <= 1'b0;
          fuse[pg_a[7:6]][pg_a[5:0]] <= 1'b1;
        end else pg_cnt <= pg_cnt - 3'd1;
      end
    end
  end

  // Log of engine starts as seen on the engine side.
  typedef struct packed { logic pg; logic [7:0] val; } ev_t;
  ev_t ev_q[$];
  always @(negedge clk) begin
    if (!rst && rd_start) ev_q.push_back('{1'b0, 8'(rd_sel)});
    if (!rst && pg_start) ev_q.push_back('{1'b1, pg_addr});
  end

  typedef struct packed { logic err; logic [SHD_W-1:0] shd; } exp_t;
  exp_t exp_q[$];

  // Reference model: fuse contents and expected shadow.
  logic [RSEL-1:0][NR-1:0] m_fuse, m_shd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [SHD_W-1:0] act, input logic [SHD_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [SHD_W-1:0] ctrl_vec();
    return SHD_W'({sw.sw_ack, sw.sw_err, load_done, ctrl_busy, rd_start, pg_start, rd_sel, pg_addr});
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sw.sw_ack) begin
        chk("ack_after_load", SHD_W'(load_done), SHD_W'(1));
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: got ack with nothing outstanding");
        end else begin
          e = exp_q.pop_front();
          chk("ack_err", SHD_W'(sw.sw_err), SHD_W'(e.err));
          chk("ack_shadow", shadow_data, e.shd);
        end
      end
    end
  endtask

  task automatic wait_ack(input int budget, output int n, output bit ok);
    ok = 1'b0; n = 0;
    while (!ok && n < budget) begin
      @(negedge clk); n++;
      if (sw.sw_ack) ok = 1'b1;
    end
  endtask

  task automatic wait_load(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk); n++;
      if (load_done) ok = 1'b1;
    end
    chk("load_done_seen", SHD_W'(ok), SHD_W'(1));
  endtask

  task automatic do_rd(input logic [BANK_W-1:0] b, input bit tmo, output int n);
    bit ok;
    if (!tmo) m_shd[b] = m_fuse[b];
    exp_q.push_back('{tmo, m_shd});
    @(negedge clk); sw.sw_rd_sel = b; sw.sw_rd_req = 1'b1;
    wait_ack(tmo ? 6000 : 200, n, ok);
    sw.sw_rd_req = 1'b0;
    chk("rd_ack_seen", SHD_W'(ok), SHD_W'(1));
  endtask

  task automatic do_pg(input logic [ADDR_W-1:0] a, input bit allow, output int n);
    bit ok;
    int idx = ev_q.size();
    logic [BANK_W-1:0] b  = BANK_W'(32'(a) / NR);
    logic [BIT_W-1:0]  bi = BIT_W'(32'(a) % NR);
    if (allow) begin
      m_fuse[b][bi] = 1'b1;
`ifdef EFUSE_RELOAD_AFTER_PGM_EN
      m_shd[b] = m_fuse[b];
`endif
    end
    exp_q.push_back('{!allow, m_shd});
    @(negedge clk); sw.sw_pg_addr = a; sw.sw_pg_allow = allow; sw.sw_pg_req = 1'b1;
    wait_ack(200, n, ok);
    sw.sw_pg_req = 1'b0;
    chk("pg_ack_seen", SHD_W'(ok), SHD_W'(1));
    if (allow) begin
      chk("pg_start_addr", SHD_W'(ev_q.size() > idx ? ev_q[idx] : '0), SHD_W'({1'b1, a}));
`ifdef EFUSE_RELOAD_AFTER_PGM_EN
      chk("reload_sel", SHD_W'(ev_q.size() > idx + 1 ? ev_q[idx+1] : '0), SHD_W'({1'b0, 8'(b)}));
`endif
    end else begin
      chk("locked_no_start", SHD_W'(ev_q.size()), SHD_W'(idx));
      chk("locked_ack_latency", SHD_W'(n), SHD_W'(1));
    end
  endtask

  initial begin
    int idx, n;
    bit ok;
    logic [SHD_W-1:0] auto_exp;

    fork monitor(); join_none

    m_fuse[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    m_fuse[1] = 64'h5A5A_5A5A_5A5A_5A5A;
    m_fuse[2] = 64'h0F0F_0F0F_0F0F_0F0F;
    m_fuse[3] = 64'hF0F0_F0F0_F0F0_F0F0;
    auto_exp  = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5};
    m_shd = '0;
    sw.sw_rd_req = 1'b0; sw.sw_rd_sel = '0; sw.sw_pg_req = 1'b0;
    sw.sw_pg_addr = '0; sw.sw_pg_allow = 1'b0;
    rd_stall = 1'b0; pg_stall = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", ctrl_vec(), '0);
    chk("reset_shadow", shadow_data, '0);

    // Read of bank 2 held from reset release: served once, after autoload.
    m_shd = m_fuse;
    exp_q.push_back('{1'b0, m_shd});
    sw.sw_rd_sel = 2'd2; sw.sw_rd_req = 1'b1;
    idx = ev_q.size();
    rst = 1'b0;
    wait_load(ok);
    chk("autoload_shadow", shadow_data, auto_exp);
    wait_ack(200, n, ok);
    sw.sw_rd_req = 1'b0;
    chk("early_rd_ack_seen", SHD_W'(ok), SHD_W'(1));
    chk("autoload_events", SHD_W'(ev_q.size() - idx), SHD_W'(5));
    for (int k = 0; k < 5; k++) begin
      logic [7:0] ev_exp;
      ev_exp = (k < 4) ? 8'(k) : 8'd2;
      chk("load_seq", SHD_W'(ev_q.size() > idx + k ? ev_q[idx+k] : '0), SHD_W'({1'b0, ev_exp}));
    end
    repeat (2) @(negedge clk);
    chk("idle_flags", SHD_W'({load_done, ctrl_busy}), SHD_W'(2'b10));

    // Program beats read when both are raised together.
    idx = ev_q.size();
    m_fuse[1][5] = 1'b1;
`ifdef EFUSE_RELOAD_AFTER_PGM_EN
    m_shd[1] = m_fuse[1];
`endif
    exp_q.push_back('{1'b0, m_shd});
    m_shd[1] = m_fuse[1];
    exp_q.push_back('{1'b0, m_shd});
    @(negedge clk);
    sw.sw_pg_addr = 8'h45; sw.sw_pg_allow = 1'b1; sw.sw_pg_req = 1'b1;
    sw.sw_rd_sel = 2'd1; sw.sw_rd_req = 1'b1;
    wait_ack(200, n, ok); sw.sw_pg_req = 1'b0;
    chk("prio_ack1", SHD_W'(ok), SHD_W'(1));
    wait_ack(200, n, ok); sw.sw_rd_req = 1'b0;
    chk("prio_ack2", SHD_W'(ok), SHD_W'(1));
    chk("prio_first_pg", SHD_W'(ev_q.size() > idx ? ev_q[idx] : '0), SHD_W'({1'b1, 8'h45}));
    chk("prio_last_rd", SHD_W'(ev_q.size() > idx + 1 ? ev_q[ev_q.size()-1] : '0), SHD_W'({1'b0, 8'd1}));

    // Locked program then a read that clears the error.
    do_pg(8'h9C, 1'b0, n);
    @(negedge clk);
    chk("locked_err_sticky", SHD_W'(sw.sw_err), SHD_W'(1));
    do_rd(2'd3, 1'b0, n);

    // Read engine never answers: watchdog ends the request.
    rd_stall = 1'b1;
    do_rd(2'd0, 1'b1, n);
    rd_stall = 1'b0;
    chk("timeout_latency", SHD_W'(n >= int'((1 << TMO_W) - 1) && n <= int'((1 << TMO_W) + 4)), SHD_W'(1));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_pg(ADDR_W'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), n);
      else
        do_rd(BANK_W'($urandom_range(0, RSEL - 1)), 1'b0, n);
    end

    // Reset while the program engine is busy, then autoload restarts.
    pg_stall = 1'b1;
    @(negedge clk); sw.sw_pg_addr = 8'h10; sw.sw_pg_allow = 1'b1; sw.sw_pg_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (pg_start) ok = 1'b1;
    end
    chk("midpg_started", SHD_W'(ok), SHD_W'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1; sw.sw_pg_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midpg_reset_ctrl", ctrl_vec(), '0);
    chk("midpg_reset_shadow", shadow_data, '0);
    pg_stall = 1'b0;
    @(negedge clk);
    idx = ev_q.size();
    m_shd = m_fuse;
    rst = 1'b0;
    wait_load(ok);
    chk("reload_shadow", shadow_data, m_shd);
    for (int k = 0; k < 4; k++)
      chk("reload_seq", SHD_W'(ev_q.size() > idx + k ? ev_q[idx+k] : '0), SHD_W'({1'b0, 8'(k)}));

    do_pg(8'hC3, 1'b1, n);
    do_rd(2'd3, 1'b0, n);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", SHD_W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
